sdram_burst_reader: RTL and testbench

//  Avalon-MM burst read master driving the HPS f2h_sdram0 data port (32-bit, word-addressed).
//  On start, streams word_count words from SDRAM, base_address upward, into an internal FIFO.
//  The FIFO feeds a valid/ready output stream to the downstream GPU/video consumer.

---
 rtl/sdram_burst_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_burst_reader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master: streams word_count words from SDRAM into an
// output FIFO that presents them as a valid/ready stream.
module sdram_burst_reader #(
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int COUNT_W    = 24
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [29:0]        base_address,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic [29:0]        avm_address,
  output logic [7:0]         avm_burstcount,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [3:0]         avm_byteenable,
  output logic [31:0]        out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = PTR_W + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Handshake: the Avalon side holds read/address/burstcount stable until
  // read && !waitrequest; the output stream transfers a word on
  // out_valid && out_ready, and out_valid never drops without a transfer.
  state_t             state_q, state_d;
  logic [29:0]        addr_q, addr_d;
  logic [COUNT_W-1:0] to_req_q, to_req_d;
  logic [COUNT_W-1:0] to_recv_q, to_recv_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic               done_q, done_d;
  logic               rd_q, rd_d;
  logic [29:0]        avm_addr_q, avm_addr_d;
  logic [7:0]         bc_q, bc_d;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
  logic [31:0]        head_q, head_d;
  logic               head_v_q, head_v_d;
  logic               mem_we;

  logic [COUNT_W-1:0] src_left;
  logic [7:0]         len_c;
  logic [SUM_W-1:0]   need_c;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               room_c, accept, push, pop, head_free;

  assign fifo_cnt  = mem_cnt_q + CNT_W'(head_v_q);
  assign accept    = rd_q && !avm_waitrequest;
  // Words arriving while idle belong to a transfer killed by reset.
  assign push      = avm_readdatavalid && (state_q != S_IDLE);
  assign pop       = head_v_q && out_ready;
  assign head_free = !head_v_q || pop;

  // A burst is only offered when every word of it already has a FIFO slot.
  always_comb begin
    src_left = (state_q == S_IDLE) ? word_count : to_req_q;
    len_c    = (src_left >= COUNT_W'(BURST_LEN)) ? 8'(BURST_LEN) : src_left[7:0];
    need_c   = SUM_W'(fifo_cnt) + SUM_W'(outst_q) + SUM_W'(len_c);
    room_c   = (need_c <= SUM_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    to_req_d   = to_req_q;
    to_recv_d  = to_recv_q;
    outst_d    = outst_q;
    done_d     = 1'b0;
    rd_d       = rd_q;
    avm_addr_d = avm_addr_q;
    bc_d       = bc_q;

    if (accept) outst_d = outst_q + CNT_W'(bc_q);
    if (push) begin
      outst_d   = outst_d - CNT_W'(1);
      to_recv_d = to_recv_q - COUNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = base_address;
          to_req_d  = word_count;
          to_recv_d = word_count;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            if (room_c) begin
              rd_d       = 1'b1;
              avm_addr_d = base_address;
              bc_d       = len_c;
            end
          end
        end
      end
      S_ISSUE: begin
        if (accept) begin
          addr_d   = addr_q + 30'(bc_q);
          to_req_d = to_req_q - COUNT_W'(bc_q);
          rd_d     = 1'b0;
          if (to_req_d == '0) state_d = S_WAIT;
        end else if (!rd_q && room_c) begin
          rd_d       = 1'b1;
          avm_addr_d = addr_q;
          bc_d       = len_c;
        end
      end
      S_WAIT: begin
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && push && (to_recv_q == COUNT_W'(1))) begin
      done_d  = 1'b1;
      rd_d    = 1'b0;
      state_d = S_IDLE;
    end
  end

  // FIFO with a registered head word; arriving data bypasses the array
  // straight into the head when nothing older is queued.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_cnt_d = mem_cnt_q;
    head_d    = head_q;
    head_v_d  = head_v_q;
    mem_we    = 1'b0;

    if (head_free) begin
      if (mem_cnt_q != '0) begin
        head_d    = mem[rd_ptr_q];
        head_v_d  = 1'b1;
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        mem_cnt_d = mem_cnt_q - CNT_W'(1);
      end else if (push) begin
        head_d   = avm_readdata;
        head_v_d = 1'b1;
      end else begin
        head_v_d = 1'b0;
      end
    end
    if (push && !(head_free && (mem_cnt_q == '0))) begin
      mem_we    = 1'b1;
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      mem_cnt_d = mem_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr_q] <= avm_readdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      to_req_q   <= '0;
      to_recv_q  <= '0;
      outst_q    <= '0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      avm_addr_q <= '0;
      bc_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_q     <= '0;
      head_v_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      to_req_q   <= to_req_d;
      to_recv_q  <= to_recv_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      rd_q       <= rd_d;
      avm_addr_q <= avm_addr_d;
      bc_q       <= bc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      head_q     <= head_d;
      head_v_q   <= head_v_d;
    end
  end

  assert property (@(posedge clock) disable iff (reset)
    !(push && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign avm_address    = avm_addr_q;
  assign avm_burstcount = bc_q;
  assign avm_read       = rd_q;
  assign avm_byteenable = 4'hF;
  assign out_data       = head_q;
  assign out_valid      = head_v_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed bench for sdram_burst_reader with a behavioural SDRAM port model
// and a consumer that records every delivered word.
module tb_sdram_burst_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [29:0] base_address = '0;
  logic [23:0] word_count = '0;
  logic        busy, done;
  logic [29:0] avm_address;
  logic [7:0]  avm_burstcount;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic [3:0]  avm_byteenable;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  dbg_state;

  sdram_burst_reader #(.BURST_LEN(64), .FIFO_DEPTH(256), .COUNT_W(24)) dut (
    .clock(clock), .reset(reset), .start(start),
    .base_address(base_address), .word_count(word_count),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_byteenable(avm_byteenable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [29:0] pend_q[$];
  logic [29:0] burst_addr_q[$];
  logic [7:0]  burst_bc_q[$];
  logic [29:0] wr_addr_q[$];
  logic [7:0]  wr_bc_q[$];
  int done_cnt = 0;
  int read_cnt = 0;
  int wr_hold = 0;
  int cyc = 0;
  int first_rdv_cyc = -1;
  int first_valid_cyc = -1;

  function automatic logic [31:0] data_of(input logic [29:0] a);
    data_of = {2'b10, a};
  endfunction

  // SDRAM model + consumer, evaluated 1 time unit after the falling edge.
  always @(negedge clock) begin
    #1;
    cyc++;
    if (reset) begin
      pend_q.delete();
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (avm_read) read_cnt++;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (out_valid && first_valid_cyc < 0 && first_rdv_cyc >= 0) first_valid_cyc = cyc;
      if (avm_read && wr_hold > 0) begin
        avm_waitrequest = 1'b1;
        wr_hold--;
        wr_addr_q.push_back(avm_address);
        wr_bc_q.push_back(avm_burstcount);
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (pend_q.size() > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = data_of(pend_q.pop_front());
        if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
      end else begin
        avm_readdatavalid = 1'b0;
      end
      if (avm_read && !avm_waitrequest) begin
        burst_addr_q.push_back(avm_address);
        burst_bc_q.push_back(avm_burstcount);
        for (int i = 0; i < int'(avm_burstcount); i++) pend_q.push_back(avm_address + 30'(i));
      end
    end
  end

  task automatic pulse_start(input logic [29:0] base, input logic [23:0] cnt);
    got_q.delete(); exp_q.delete(); burst_addr_q.delete(); burst_bc_q.delete();
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(data_of(base + 30'(i)));
    base_address = base;
    word_count = cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    for (int i = 0; i < limit && done_cnt == d0; i++) @(negedge clock);
    @(negedge clock);
  endtask

  task automatic wait_drain(input int n, input int limit);
    for (int i = 0; i < limit && got_q.size() < n; i++) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({busy, done, avm_read, out_valid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, avm_read, out_valid});
    end
    tests_run++;
    if (avm_address !== 30'h0 || avm_burstcount !== 8'h0) begin
      tests_failed++;
      $display("FAIL reset_addr got=%h/%h exp=0/0", avm_address, avm_burstcount);
    end
    tests_run++;
    if (avm_byteenable !== 4'hF) begin
      tests_failed++;
      $display("FAIL byteenable got=%h exp=f", avm_byteenable);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_zero_count;
    int d0 = done_cnt;
    int r0 = read_cnt;
    pulse_start(30'h55, 24'd0);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    repeat (4) @(negedge clock);
    tests_run++;
    if (done_cnt !== d0 + 1 || read_cnt !== r0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_after got done_cnt=%0d reads=%0d busy=%b exp %0d %0d 0",
               done_cnt, read_cnt, busy, d0 + 1, r0);
    end
  endtask

  task automatic test_single_burst;
    int d0 = done_cnt;
    first_rdv_cyc = -1;
    first_valid_cyc = -1;
    out_ready = 1'b1;
    pulse_start(30'h100, 24'd64);
    tests_run++;
    if ({avm_read, busy} !== 2'b11 || avm_address !== 30'h100 || avm_burstcount !== 8'd64) begin
      tests_failed++;
      $display("FAIL single_issue got read=%b busy=%b addr=%h bc=%0d exp 1 1 100 64",
               avm_read, busy, avm_address, avm_burstcount);
    end
    wait_done(d0, 400);
    wait_drain(64, 50);
    repeat (3) @(negedge clock);
    tests_run++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done got done_cnt=%0d busy=%b exp %0d 0", done_cnt, busy, d0 + 1);
    end
    tests_run++;
    if (burst_addr_q.size() !== 1 || burst_addr_q[0] !== 30'h100 || burst_bc_q[0] !== 8'd64) begin
      tests_failed++;
      $display("FAIL single_bursts got n=%0d exp n=1 addr=100 bc=64", burst_addr_q.size());
    end
    tests_run++;
    if (first_valid_cyc - first_rdv_cyc !== 1) begin
      tests_failed++;
      $display("FAIL rdv_latency got=%0d exp=1", first_valid_cyc - first_rdv_cyc);
    end
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL single_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL single_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_multi_burst;
    logic [29:0] ea [3] = '{30'h0, 30'h40, 30'h80};
    logic [7:0]  eb [3] = '{8'd64, 8'd64, 8'd22};
    int d0 = done_cnt;
    pulse_start(30'h0, 24'd150);
    wait_done(d0, 800);
    wait_drain(150, 100);
    tests_run++;
    if (burst_addr_q.size() !== 3) begin
      tests_failed++;
      $display("FAIL multi_nbursts got=%0d exp=3", burst_addr_q.size());
    end
    for (int i = 0; i < 3 && i < burst_addr_q.size(); i++) begin
      tests_run++;
      if (burst_addr_q[i] !== ea[i] || burst_bc_q[i] !== eb[i]) begin
        tests_failed++;
        $display("FAIL multi_burst[%0d] got=%h/%0d exp=%h/%0d", i, burst_addr_q[i],
                 burst_bc_q[i], ea[i], eb[i]);
      end
    end
    tests_run++;
    if (got_q.size() !== 150 || done_cnt !== d0 + 1) begin
      tests_failed++;
      $display("FAIL multi_count got words=%0d done=%0d exp 150 %0d", got_q.size(), done_cnt, d0 + 1);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL multi_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int d0 = done_cnt;
    out_ready = 1'b0;
    pulse_start(30'h4000, 24'd1024);
    repeat (600) @(negedge clock);
    tests_run++;
    if (burst_addr_q.size() !== 4 || got_q.size() !== 0 || out_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_stall got bursts=%0d words=%0d valid=%b busy=%b exp 4 0 1 1",
               burst_addr_q.size(), got_q.size(), out_valid, busy);
    end
    out_ready = 1'b1;
    wait_done(d0, 4000);
    wait_drain(1024, 400);
    tests_run++;
    if (burst_addr_q.size() !== 16 || got_q.size() !== 1024 || done_cnt !== d0 + 1) begin
      tests_failed++;
      $display("FAIL bp_total got bursts=%0d words=%0d done=%0d exp 16 1024 %0d",
               burst_addr_q.size(), got_q.size(), done_cnt, d0 + 1);
    end
    for (int i = 0; i < burst_addr_q.size(); i++) begin
      tests_run++;
      if (burst_addr_q[i] !== 30'h4000 + 30'(64 * i) || burst_bc_q[i] !== 8'd64) begin
        tests_failed++;
        $display("FAIL bp_burst[%0d] got=%h/%0d exp=%h/64", i, burst_addr_q[i], burst_bc_q[i],
                 30'h4000 + 30'(64 * i));
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_waitrequest;
    int d0 = done_cnt;
    wr_addr_q.delete();
    wr_bc_q.delete();
    wr_hold = 10;
    pulse_start(30'h200, 24'd64);
    wait_done(d0, 500);
    wait_drain(64, 50);
    tests_run++;
    if (wr_addr_q.size() !== 10) begin
      tests_failed++;
      $display("FAIL wr_cycles got=%0d exp=10", wr_addr_q.size());
    end
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      tests_run++;
      if (wr_addr_q[i] !== 30'h200 || wr_bc_q[i] !== 8'd64) begin
        tests_failed++;
        $display("FAIL wr_stable[%0d] got=%h/%0d exp=200/64", i, wr_addr_q[i], wr_bc_q[i]);
      end
    end
    tests_run++;
    if (got_q.size() !== 64 || burst_addr_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL wr_done got words=%0d bursts=%0d exp 64 1", got_q.size(), burst_addr_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL wr_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int d0;
    pulse_start(30'h1000, 24'd512);
    for (int i = 0; i < 500 && burst_addr_q.size() < 2; i++) @(negedge clock);
    tests_run++;
    if (burst_addr_q.size() < 2) begin
      tests_failed++;
      $display("FAIL mid_progress got bursts=%0d exp>=2", burst_addr_q.size());
    end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({busy, out_valid, avm_read} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_reset got busy/valid/read=%b exp=000", {busy, out_valid, avm_read});
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    d0 = done_cnt;
    pulse_start(30'h3000, 24'd100);
    wait_done(d0, 800);
    wait_drain(100, 100);
    tests_run++;
    if (got_q.size() !== 100 || done_cnt !== d0 + 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_restart got words=%0d done=%0d busy=%b exp 100 %0d 0",
               got_q.size(), done_cnt, busy, d0 + 1);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL mid_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_single_burst();
    test_multi_burst();
    test_backpressure();
    test_waitrequest();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
